// File: rtl/dmem_pkg.sv
// Purpose: shared types and constants for the dcache-port to AXI4-Lite bridge.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: FSM state enum, request size codes, AXI response codes, and the base byte-strobe helper.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_WR,
        ST_B,
        ST_RESP
    } state_t;

    // Request size codes (func3[1:0])
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    // Byte strobe for an access of the given size at byte lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] len);
        logic [7:0] m;
        case (len)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_axi_bridge_if.sv
// Purpose: AXI4-Lite-style 64-bit bus between the bridge (master) and memory (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready on the AR, R, AW, W and B channels.
// Ports: ar*, r*, aw*, w*, b* channels; modports master (bridge side) and slave (memory side).
interface dmem_axi_bridge_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Purpose: byte-lane alignment between LSB-justified pipeline data and the 64-bit bus.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its inputs).
// Ports: addr_lo/len select the lanes; wdata -> wdata_sh/wstrb/misalign; rdata -> rdata_al.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  addr_lo,
    input  logic [1:0]  len,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [63:0] wdata_sh,
    output logic [7:0]  wstrb,
    output logic        misalign,
    output logic [63:0] rdata_al
);

    logic [5:0]  bit_off;
    logic [63:0] rdata_sh;

    assign bit_off = {addr_lo, 3'b000};

    always_comb begin
        wdata_sh = wdata << bit_off;
        wstrb    = size_mask(len) << addr_lo;
        misalign = 1'b0;
        case (len)
            SZ_H:    misalign = addr_lo[0];
            SZ_W:    misalign = |addr_lo[1:0];
            SZ_D:    misalign = |addr_lo;
            default: misalign = 1'b0;
        endcase
    end

    // Load data: bring the addressed lane down to bit 0, then zero-fill above the size.
    always_comb begin
        rdata_sh = rdata >> bit_off;
        rdata_al = rdata_sh;
        case (len)
            SZ_B:    rdata_al = {56'd0, rdata_sh[7:0]};
            SZ_H:    rdata_al = {48'd0, rdata_sh[15:0]};
            SZ_W:    rdata_al = {32'd0, rdata_sh[31:0]};
            default: rdata_al = rdata_sh;
        endcase
    end

endmodule

// File: rtl/dmem_axi_bridge.sv
// Purpose: turns one dcache-port load/store into a single AXI4-Lite-style 64-bit transaction.
// Latency: zero-wait slave gives a response 3 cycles after accept; a rejected request responds after 1 cycle.
// Backpressure: req_ready only in IDLE (one access in flight); bus valids hold until their handshake.
// Ports: clk, rst_n; req_* (request in), resp_* (one-cycle response pulse), m (AXI master modport).
module dmem_axi_bridge
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_len,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    dmem_axi_bridge_if.master m
);

    if (DATA_W != 64) begin : g_bad_data_w
        $error("dmem_axi_bridge: DATA_W must be 64");
    end

    state_t            state_q, state_d;
    logic [2:0]        addr_lo_q;
    logic [1:0]        len_q;
    logic              aw_done_q, w_done_q;
    logic [ADDR_W-1:0] araddr_q, awaddr_q;
    logic [63:0]       wdata_q;
    logic [7:0]        wstrb_q;
    logic [63:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_bad;
    logic [ADDR_W-1:0] aligned_addr;
    logic              aw_hs, w_hs;
    logic              aw_done_n, w_done_n;

    logic [2:0]        al_off;
    logic [1:0]        al_len;
    logic [63:0]       wdata_sh, rdata_al;
    logic [7:0]        wstrb;
    logic              misalign;

    // The aligner serves the write side while idle (live request) and the read side
    // afterwards (registered offset/size), so one instance covers both.
    assign al_off = (state_q == ST_IDLE) ? req_addr[2:0] : addr_lo_q;
    assign al_len = (state_q == ST_IDLE) ? req_len       : len_q;

    dmem_lane_align u_align (
        .addr_lo  (al_off),
        .len      (al_len),
        .wdata    (req_wdata),
        .rdata    (m.rdata),
        .wdata_sh (wdata_sh),
        .wstrb    (wstrb),
        .misalign (misalign),
        .rdata_al (rdata_al)
    );

    assign accept       = req_valid && req_ready;
    assign req_bad      = (req_read == req_write) || misalign;
    assign aligned_addr = {req_addr[ADDR_W-1:3], 3'b000};

    assign aw_hs     = m.awvalid && m.awready;
    assign w_hs      = m.wvalid  && m.wready;
    assign aw_done_n = aw_done_q || aw_hs;
    assign w_done_n  = w_done_q  || w_hs;

    // All handshake outputs decode the registered state, so no ready feeds a valid.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign m.arvalid  = (state_q == ST_AR);
    assign m.rready   = (state_q == ST_R);
    assign m.awvalid  = (state_q == ST_WR) && !aw_done_q;
    assign m.wvalid   = (state_q == ST_WR) && !w_done_q;
    assign m.bready   = (state_q == ST_B);
    assign m.araddr   = araddr_q;
    assign m.awaddr   = awaddr_q;
    assign m.wdata    = wdata_q;
    assign m.wstrb    = wstrb_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad)       state_d = ST_RESP;
                    else if (req_read) state_d = ST_AR;
                    else               state_d = ST_WR;
                end
            end
            ST_AR:   if (m.arready) state_d = ST_R;
            ST_R:    if (m.rvalid)  state_d = ST_RESP;
            // Covers AW and W finishing in the same cycle as well as in either order.
            ST_WR:   if (aw_done_n && w_done_n) state_d = ST_B;
            ST_B:    if (m.bvalid)  state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_q <= 3'd0;
            len_q     <= 2'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= 64'd0;
            wstrb_q   <= 8'd0;
            rdata_q   <= 64'd0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_lo_q <= req_addr[2:0];
                        len_q     <= req_len;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (req_bad) begin
                            // Rejected without bus traffic; load data from the last access is kept.
                            err_q <= 1'b1;
                        end else if (req_read) begin
                            araddr_q <= aligned_addr;
                        end else begin
                            awaddr_q <= aligned_addr;
                            wdata_q  <= wdata_sh;
                            wstrb_q  <= wstrb;
                        end
                    end
                end
                ST_R: begin
                    if (m.rvalid) begin
                        rdata_q <= rdata_al;
                        err_q   <= (m.rresp != OKAY);
                    end
                end
                ST_WR: begin
                    aw_done_q <= aw_done_n;
                    w_done_q  <= w_done_n;
                end
                ST_B: begin
                    if (m.bvalid) err_q <= (m.bresp != OKAY);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Purpose: directed scoreboard bench for dmem_axi_bridge with a scripted AXI slave.
// Latency: expected response latency is recorded per request and checked on resp_valid.
// Backpressure: slave inserts wait cycles on AR, AW and W to exercise held valids.
module tb_dmem_axi_bridge;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_len;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    dmem_axi_bridge_if #(.ADDR_W(64)) bus ();

    dmem_axi_bridge #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .m          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    bus_cnt = 0;
    int    resp_cnt = 0;
    int    n_push = 0;
    string tname = "reset";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%h, expected 0x%h", tname, name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s/%s: timed out waiting, expected DUT event", tname, name);
    endtask

    task automatic push(input logic [63:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = lat;
        sb.push_back(e);
        n_push++;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: counts bus address activity and checks every response against the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus.arvalid === 1'b1 || bus.awvalid === 1'b1) bus_cnt++;
        if (resp_valid === 1'b1) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s/unexpected_resp: got resp_valid=1, expected no response", tname);
            end else begin
                e = sb.pop_front();
                check("resp_err",     {63'd0, resp_err}, {63'd0, e.err});
                check("resp_rdata",   resp_rdata, e.rdata);
                check("resp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
            end
        end
    end

    task automatic issue_req(input logic [63:0] addr, input logic rd, input logic wr,
                             input logic [1:0] len, input logic [63:0] wdata);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_read  = rd;
        req_write = wr;
        req_len   = len;
        req_wdata = wdata;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout_fail("req_ready");
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        // Request inputs are don't-care after accept; scramble them.
        req_valid = 1'b0;
        req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
        req_read  = 1'b0;
        req_write = 1'b1;
        req_len   = 2'd0;
        req_wdata = 64'h5555_5555_5555_5555;
    endtask

    task automatic slave_read(input int ar_wait, input logic [63:0] data,
                              input logic [1:0] resp, input logic [63:0] exp_addr);
        int n = 0;
        logic stable = 1'b1;
        @(negedge clk);
        while (bus.arvalid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            timeout_fail("arvalid");
            return;
        end
        check("araddr", bus.araddr, exp_addr);
        repeat (ar_wait) begin
            if (bus.arvalid !== 1'b1 || bus.araddr !== exp_addr) stable = 1'b0;
            @(negedge clk);
        end
        if (ar_wait > 0) check("arvalid_stable", {63'd0, stable}, 64'd1);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = data;
        bus.rresp   = resp;
        @(negedge clk);
        bus.rvalid  = 1'b0;
        bus.rdata   = 64'd0;
        bus.rresp   = OKAY;
    endtask

    task automatic slave_write(input int aw_wait, input int w_wait, input logic [1:0] resp,
                               input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                               input logic [7:0] exp_wstrb);
        int n = 0;
        @(negedge clk);
        while (bus.awvalid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            timeout_fail("awvalid");
            return;
        end
        check("awaddr", bus.awaddr, exp_addr);
        check("wdata",  bus.wdata, exp_wdata);
        check("wstrb",  {56'd0, bus.wstrb}, {56'd0, exp_wstrb});
        check("wvalid_with_awvalid", {63'd0, bus.wvalid}, 64'd1);
        fork
            begin
                logic st = 1'b1;
                repeat (aw_wait) begin
                    if (bus.awvalid !== 1'b1) st = 1'b0;
                    @(negedge clk);
                end
                if (aw_wait > 0) check("awvalid_stable", {63'd0, st}, 64'd1);
                bus.awready = 1'b1;
                @(negedge clk);
                bus.awready = 1'b0;
                check("awvalid_drop", {63'd0, bus.awvalid}, 64'd0);
            end
            begin
                logic st = 1'b1;
                repeat (w_wait) begin
                    if (bus.wvalid !== 1'b1) st = 1'b0;
                    @(negedge clk);
                end
                if (w_wait > 0) check("wvalid_stable", {63'd0, st}, 64'd1);
                bus.wready = 1'b1;
                @(negedge clk);
                bus.wready = 1'b0;
                check("wvalid_drop", {63'd0, bus.wvalid}, 64'd0);
            end
        join
        check("bready", {63'd0, bus.bready}, 64'd1);
        bus.bvalid = 1'b1;
        bus.bresp  = resp;
        @(negedge clk);
        bus.bvalid = 1'b0;
        bus.bresp  = OKAY;
    endtask

    task automatic do_load(input string nm, input logic [63:0] addr, input logic [1:0] len,
                           input int ar_wait, input logic [63:0] data, input logic [1:0] resp,
                           input logic [63:0] exp_araddr, input logic [63:0] exp_rdata,
                           input logic exp_err, input int lat);
        tname = nm;
        push(exp_rdata, exp_err, lat);
        fork
            issue_req(addr, 1'b1, 1'b0, len, 64'd0);
            slave_read(ar_wait, data, resp, exp_araddr);
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic do_store(input string nm, input logic [63:0] addr, input logic [1:0] len,
                            input logic [63:0] wdata, input int aw_wait, input int w_wait,
                            input logic [1:0] resp, input logic [63:0] exp_awaddr,
                            input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb,
                            input logic [63:0] hold_rdata, input logic exp_err, input int lat);
        tname = nm;
        push(hold_rdata, exp_err, lat);
        fork
            issue_req(addr, 1'b0, 1'b1, len, wdata);
            slave_write(aw_wait, w_wait, resp, exp_awaddr, exp_wdata, exp_wstrb);
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reject(input string nm, input logic [63:0] addr, input logic rd,
                             input logic wr, input logic [1:0] len, input logic [63:0] hold_rdata);
        int base;
        tname = nm;
        base = bus_cnt;
        push(hold_rdata, 1'b1, 1);
        issue_req(addr, rd, wr, len, 64'hDEAD_BEEF_DEAD_BEEF);
        repeat (4) @(negedge clk);
        check("no_bus_traffic", 64'(bus_cnt - base), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = 64'd0;
        req_read    = 1'b0;
        req_write   = 1'b0;
        req_len     = 2'd0;
        req_wdata   = 64'd0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 64'd0;
        bus.rresp   = OKAY;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = OKAY;
        repeat (3) @(negedge clk);

        check("req_ready",  {63'd0, req_ready}, 64'd1);
        check("resp_valid", {63'd0, resp_valid}, 64'd0);
        check("bus_valids", {59'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 64'd0);
        check("araddr",     bus.araddr, 64'd0);
        check("wstrb",      {56'd0, bus.wstrb}, 64'd0);
        check("resp_rdata", resp_rdata, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_load("ld_dword", 64'h8000_0010, SZ_D, 0, 64'h1122_3344_5566_7788, OKAY,
                64'h8000_0010, 64'h1122_3344_5566_7788, 1'b0, 3);
        do_load("ld_byte",  64'h8000_0015, SZ_B, 0, 64'h1122_3344_5566_7788, OKAY,
                64'h8000_0010, 64'h0000_0000_0000_0033, 1'b0, 3);
        do_load("ld_half",  64'h8000_0016, SZ_H, 0, 64'h1122_3344_5566_7788, OKAY,
                64'h8000_0010, 64'h0000_0000_0000_1122, 1'b0, 3);
        do_load("ld_word",  64'h8000_0014, SZ_W, 0, 64'h1122_3344_5566_7788, OKAY,
                64'h8000_0010, 64'h0000_0000_1122_3344, 1'b0, 3);

        do_store("st_half_aw_first", 64'h8000_0006, SZ_H, 64'hFFFF_FFFF_FFFF_BEEF, 0, 3, OKAY,
                 64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0000_0000_1122_3344, 1'b0, 6);
        do_store("st_half_w_first",  64'h8000_0006, SZ_H, 64'h0000_0000_0000_BEEF, 3, 0, OKAY,
                 64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0000_0000_1122_3344, 1'b0, 6);
        do_store("st_dword_decerr",  64'h8000_0008, SZ_D, 64'hA5A5_5A5A_0123_4567, 0, 0, DECERR,
                 64'h8000_0008, 64'hA5A5_5A5A_0123_4567, 8'hFF, 64'h0000_0000_1122_3344, 1'b1, 3);

        do_reject("st_word_misalign", 64'h8000_0002, 1'b0, 1'b1, SZ_W, 64'h0000_0000_1122_3344);
        do_reject("rd_and_wr",        64'h8000_0000, 1'b1, 1'b1, SZ_D, 64'h0000_0000_1122_3344);

        do_load("ld_slverr", 64'h8000_0020, SZ_D, 5, 64'hCAFE_F00D_1234_5678, SLVERR,
                64'h8000_0020, 64'hCAFE_F00D_1234_5678, 1'b1, 8);

        // Reset while waiting for read data: no response may follow.
        tname = "reset_in_r";
        fork
            issue_req(64'h8000_0030, 1'b1, 1'b0, SZ_D, 64'd0);
            begin
                n = 0;
                @(negedge clk);
                while (bus.arvalid !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) timeout_fail("arvalid");
                bus.arready = 1'b1;
                @(negedge clk);
                bus.arready = 1'b0;
            end
        join
        check("rready_before_rst", {63'd0, bus.rready}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rready_async_drop", {63'd0, bus.rready}, 64'd0);
        check("req_ready_in_rst",  {63'd0, req_ready}, 64'd1);
        check("rdata_in_rst",      resp_rdata, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_load("ld_after_rst", 64'h8000_0008, SZ_D, 0, 64'h0F1E_2D3C_4B5A_6978, OKAY,
                64'h8000_0008, 64'h0F1E_2D3C_4B5A_6978, 1'b0, 3);

        repeat (4) @(negedge clk);
        tname = "end";
        check("sb_empty",   64'(sb.size()), 64'd0);
        check("resp_count", 64'(resp_cnt), 64'(n_push));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_axi_bridge.md
Name: dmem_axi_bridge

Overview:
Sits directly downstream of the load/store stage's dcache request port. It turns one load or store request (address, size, data) into a single AXI4-Lite-style 64-bit transaction. It returns lane-aligned read data or a write completion to the pipeline as a one-cycle response pulse. Uncached and blocking: at most one transaction in flight.

Parameters:
- ADDR_W, 64, request and bus address width.
- DATA_W, 64, bus data width; fixed at 64, any other value is a configuration error.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_addr  in  ADDR_W  byte address (rs1+imm)
- req_read  in  1  load request
- req_write  in  1  store request
- req_len  in  2  size: 0 byte, 1 half, 2 word, 3 dword (func3[1:0])
- req_wdata  in  64  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  load data, LSB-justified, zero-filled above size
- resp_err  out  1  qualifies resp_valid: access fault
- m_araddr  out  ADDR_W  read address, 8-byte aligned
- m_arvalid  out  1  read address valid
- m_arready  in  1  read address ready
- m_rdata  in  64  read data
- m_rresp  in  2  read response
- m_rvalid  in  1  read data valid
- m_rready  out  1  read data ready
- m_awaddr  out  ADDR_W  write address, 8-byte aligned
- m_awvalid  out  1  write address valid
- m_awready  in  1  write address ready
- m_wdata  out  64  write data, lane-shifted
- m_wstrb  out  8  byte strobes
- m_wvalid  out  1  write data valid
- m_wready  in  1  write data ready
- m_bresp  in  2  write response
- m_bvalid  in  1  write response valid
- m_bready  out  1  write response ready

Behaviour:
- Reset values:
  - state IDLE; req_ready 1.
  - resp_valid, resp_err, all m_*valid, m_rready, m_bready 0.
  - resp_rdata, m_araddr, m_awaddr, m_wdata 0; m_wstrb 0.
- Reset mid-transaction: the transaction is abandoned; bus valids drop asynchronously; no response is issued.
- Accept rule: accept when req_valid && req_ready. req_ready = (state == IDLE).
  - addr, len, rw, and wdata are registered at accept; request inputs are don't-care afterwards.
- Error at accept: any of the following goes to RESP with resp_err=1 and no bus traffic, so resp_valid appears 1 cycle after accept:
  - req_read == req_write (both or neither set);
  - addr misaligned for size: len1 & addr[0], len2 & |addr[1:0], len3 & |addr[2:0].
- States: IDLE, AR, R, WR, B, RESP.
- Read path:
  - IDLE→AR: m_arvalid=1, m_araddr = addr & ~7.
  - AR→R on m_arready: m_rready=1.
  - R→RESP on m_rvalid: capture resp_rdata = (m_rdata >> 8*addr[2:0]) masked to size; resp_err = (m_rresp != 0).
- Write path:
  - IDLE→WR: m_awvalid=1 and m_wvalid=1 together.
    - m_wdata = wdata << 8*addr[2:0].
    - m_wstrb = {1,3,F,FF}[len] << addr[2:0].
  - AW and W complete independently; each valid drops the cycle after its own handshake (tracked by aw_done/w_done).
  - WR→B when both are done, including a same-cycle handshake: m_bready=1.
  - B→RESP on m_bvalid; resp_err = (m_bresp != 0); resp_rdata unchanged.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold until the next RESP.
- Bus valids stay stable until handshake (AXI rule); no combinational path from any m_*ready to any m_*valid.
- Minimum latency with a zero-wait slave: load accept at cycle 0 → arvalid cycle 1 → rvalid cycle 2 → resp_valid cycle 3. Stores are the same with B in place of R.
- Back-to-back: a new request is accepted in IDLE the cycle after RESP; throughput is at most 1 access per 4 cycles.

Decomposition:
- dmem_pkg:
  - state enum;
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - AXI resp constants OKAY=0, SLVERR=2, DECERR=3;
  - function size_mask(len) returning the 8-bit base strobe.
- One combinational sub-module, dmem_lane_align:
  - write side: given addr[2:0], len, and data, produces shifted wdata, wstrb, and misalign;
  - read side: produces right-shifted, size-masked rdata.
- The FSM stays in dmem_axi_bridge.

Test Plan:
- Load dword, addr 0x8000_0010, zero-wait slave returns 0x1122334455667788 → araddr 0x8000_0010; resp_valid at cycle 3; rdata 0x1122334455667788; err 0.
- Load byte, addr 0x8000_0015, rdata 0x1122334455667788 → araddr 0x8000_0010; resp_rdata 0x0000_0000_0000_0033.
- Store half 0xBEEF, addr 0x8000_0006 → awaddr 0x8000_0000; wstrb 0xC0; wdata 0xBEEF_0000_0000_0000.
  - Case a: awready 3 cycles before wready → single B phase, one resp_valid.
  - Case b: wready before awready → same result.
- Store word to addr 0x8000_0002 → resp_valid+resp_err 1 cycle after accept; no arvalid/awvalid ever asserted.
- Load with rresp=SLVERR after 5 wait cycles on arready → arvalid held stable 5 cycles; resp_err=1.
- rst_n low while in R (rvalid not yet seen) → rready and state drop immediately; no resp_valid; next load after reset completes normally.
